// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and constants for the round-robin arbiter
package rr_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arbiter_4_if.sv
// rtl/rr_arbiter_4_if.sv - request/grant bundle between requesters and the arbiter
interface rr_arbiter_4_if;
  import rr_arb_pkg::*;

  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               busy;

  // master: requester side; slave: the arbiter itself
  modport master (output en, output req, input gnt, input gnt_idx, input busy);
  modport slave  (input en, input req, output gnt, output gnt_idx, output busy);
endinterface

// File: rtl/decoder_2x4_en.sv
// rtl/decoder_2x4_en.sv - 2-to-4 one-hot decoder with output enable
module decoder_2x4_en
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] out_o
);
  assign out_o = en_i ? (NUM_REQ'(1) << idx_i) : '0;
endmodule

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-way round-robin arbiter with bounded grant hold
module rr_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_4_if.slave  bus
);
  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       hold_q, hold_d;
  logic             release_grant;
  logic             gnt_en;

  // First requester at or after the priority pointer, wrapping mod 4.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                   input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] w;
    logic [IDX_W-1:0] c;
    logic             found;
    w     = p;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = p + IDX_W'(k);
      if (!found && r[c]) begin
        w     = c;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  assign release_grant = !bus.en || !bus.req[idx_q] || (hold_q == 8'(HOLD_MAX - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (bus.en && (bus.req != '0)) begin
          state_d = GRANT;
          idx_d   = pick_winner(bus.req, ptr_q);
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          state_d = IDLE;
          ptr_d   = idx_q + IDX_W'(1);
        end else begin
          hold_d  = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_en      = (state_q == GRANT);
    bus.busy    = gnt_en;
    bus.gnt_idx = idx_q;
  end

  decoder_2x4_en u_gnt_dec (
    .idx_i (idx_q),
    .en_i  (gnt_en),
    .out_o (bus.gnt)
  );
endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - directed self-checking bench for rr_arbiter_4
module tb_rr_arbiter_4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [3:0] req = 4'b0000;
  int         checks = 0;
  int         failures = 0;

  rr_arbiter_4_if if8 ();
  rr_arbiter_4_if if1 ();

  assign if8.en  = en;
  assign if8.req = req;
  assign if1.en  = en;
  assign if1.req = req;

  rr_arbiter_4 #(.HOLD_MAX(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  rr_arbiter_4 #(.HOLD_MAX(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    en    = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'hF;
    en    = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (if8.gnt !== 4'b0000 || if8.busy !== 1'b0 || if8.gnt_idx !== 2'd0) begin
        failures++;
        $display("FAIL reset_hold c%0d got gnt=%b busy=%b idx=%0d exp gnt=0000 busy=0 idx=0",
                 c, if8.gnt, if8.busy, if8.gnt_idx);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (if8.gnt !== 4'b0001 || if8.busy !== 1'b1 || if8.gnt_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_first_grant got gnt=%b busy=%b idx=%0d exp gnt=0001 busy=1 idx=0",
               if8.gnt, if8.busy, if8.gnt_idx);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (if8.gnt !== 4'b0100 || if8.gnt_idx !== 2'd2) begin
        failures++;
        $display("FAIL single_grant c%0d got gnt=%b idx=%0d exp gnt=0100 idx=2",
                 c, if8.gnt, if8.gnt_idx);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (if8.gnt !== 4'b0000 || if8.busy !== 1'b0 || if8.gnt_idx !== 2'd2) begin
      failures++;
      $display("FAIL single_release got gnt=%b busy=%b idx=%0d exp gnt=0000 busy=0 idx=2",
               if8.gnt, if8.busy, if8.gnt_idx);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    do_reset();
    req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << (g % 4);
      for (int c = 0; c < 8; c++) begin
        tick();
        checks++;
        if (if8.gnt !== exp) begin
          failures++;
          $display("FAIL rotation_grant g%0d c%0d got=%b exp=%b", g, c, if8.gnt, exp);
        end
      end
      tick();
      checks++;
      if (if8.gnt !== 4'b0000) begin
        failures++;
        $display("FAIL rotation_guard g%0d got=%b exp=0000", g, if8.gnt);
      end
    end
  endtask

  task automatic test_skip();
    do_reset();
    req = 4'b0001;
    tick();
    checks++;
    if (if8.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL skip_serve0 got=%b exp=0001", if8.gnt);
    end
    req = 4'b0000;
    tick();
    req = 4'b1001;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (if8.gnt !== 4'b1000 || if8.gnt_idx !== 2'd3) begin
        failures++;
        $display("FAIL skip_to3 c%0d got gnt=%b idx=%0d exp gnt=1000 idx=3",
                 c, if8.gnt, if8.gnt_idx);
      end
    end
    tick();
    checks++;
    if (if8.gnt !== 4'b0000) begin
      failures++;
      $display("FAIL skip_guard got=%b exp=0000", if8.gnt);
    end
    tick();
    checks++;
    if (if8.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL skip_back_to0 got=%b exp=0001", if8.gnt);
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    req = 4'b0010;
    tick();
    checks++;
    if (if8.gnt !== 4'b0010) begin
      failures++;
      $display("FAIL endrop_grant1 got=%b exp=0010", if8.gnt);
    end
    req = 4'b0110;
    tick();
    checks++;
    if (if8.gnt !== 4'b0010) begin
      failures++;
      $display("FAIL endrop_no_preempt got=%b exp=0010", if8.gnt);
    end
    en = 1'b0;
    tick();
    checks++;
    if (if8.gnt !== 4'b0000 || if8.busy !== 1'b0) begin
      failures++;
      $display("FAIL endrop_release got gnt=%b busy=%b exp gnt=0000 busy=0", if8.gnt, if8.busy);
    end
    tick();
    checks++;
    if (if8.gnt !== 4'b0000) begin
      failures++;
      $display("FAIL endrop_idle got=%b exp=0000", if8.gnt);
    end
    en = 1'b1;
    tick();
    checks++;
    if (if8.gnt !== 4'b0100 || if8.gnt_idx !== 2'd2) begin
      failures++;
      $display("FAIL endrop_resume got gnt=%b idx=%0d exp gnt=0100 idx=2", if8.gnt, if8.gnt_idx);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    checks++;
    if (if8.gnt !== 4'b0100) begin
      failures++;
      $display("FAIL midrst_grant got=%b exp=0100", if8.gnt);
    end
    rst_n = 1'b0;
    req   = 4'b1010;
    tick();
    checks++;
    if (if8.gnt !== 4'b0000 || if8.gnt_idx !== 2'd0) begin
      failures++;
      $display("FAIL midrst_drop got gnt=%b idx=%0d exp gnt=0000 idx=0", if8.gnt, if8.gnt_idx);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (if8.gnt !== 4'b0010 || if8.gnt_idx !== 2'd1) begin
      failures++;
      $display("FAIL midrst_ptr got gnt=%b idx=%0d exp gnt=0010 idx=1", if8.gnt, if8.gnt_idx);
    end
  endtask

  task automatic test_hold1();
    logic [3:0] exp_tab [8];
    exp_tab = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (if1.gnt !== exp_tab[c]) begin
        failures++;
        $display("FAIL hold1_alternate c%0d got=%b exp=%b", c, if1.gnt, exp_tab[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_skip();
    test_en_drop();
    test_reset_mid_grant();
    test_hold1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
